// File: rtl/alu_exec_sequencer_pkg.sv
// Shared widths, ALU opcodes and FSM state encoding for the execute-stage sequencer.
package alu_exec_sequencer_pkg;

   localparam int unsigned DATA_BUS_WIDTH  = 24;
   localparam int unsigned ALU_OP_NUM_BITS = 3;

   typedef enum logic [ALU_OP_NUM_BITS-1:0] {
      ALU_OP_ADD   = 3'd0,
      ALU_OP_SUB   = 3'd1,
      ALU_OP_AND   = 3'd2,
      ALU_OP_OR    = 3'd3,
      ALU_OP_XOR   = 3'd4,
      ALU_OP_NOT   = 3'd5,
      ALU_OP_INCR  = 3'd6,
      ALU_OP_UNDEF = 3'd7
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LATCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Only the arithmetic ops own the carry flag; logic ops leave it untouched.
   function automatic logic op_sets_carry(input logic [ALU_OP_NUM_BITS-1:0] op);
      return (op == ALU_OP_ADD) || (op == ALU_OP_SUB) || (op == ALU_OP_INCR);
   endfunction

endpackage

// File: rtl/alu_exec_sequencer_alu.sv
// Combinational ALU: 25-bit internal answer so bit 24 carries the carry/borrow out.
module alu_exec_sequencer_alu
   import alu_exec_sequencer_pkg::*;
(
   input  logic [DATA_BUS_WIDTH-1:0]  a,
   input  logic [DATA_BUS_WIDTH-1:0]  b,
   input  logic [ALU_OP_NUM_BITS-1:0] ALU_OP,
   output logic [DATA_BUS_WIDTH-1:0]  result,
   output logic                       Z,
   output logic                       C,
   output logic                       N
);

   localparam logic [DATA_BUS_WIDTH:0] ONE = 1;

   logic [DATA_BUS_WIDTH:0] wide;

   always_comb begin
      wide = '0;
      case (ALU_OP)
         ALU_OP_ADD:  wide = {1'b0, a} + {1'b0, b};
         // Borrow-style subtract: inverting the zero-extended b sets bit 24 when a < b.
         ALU_OP_SUB:  wide = {1'b0, a} + ~{1'b0, b} + ONE;
         ALU_OP_AND:  wide = {1'b0, a & b};
         ALU_OP_OR:   wide = {1'b0, a | b};
         ALU_OP_XOR:  wide = {1'b0, a ^ b};
         ALU_OP_NOT:  wide = {1'b0, ~a};
         ALU_OP_INCR: wide = {1'b0, a} + ONE;
         default:     wide = '0;
      endcase
   end

   assign result = wide[DATA_BUS_WIDTH-1:0];
   assign C      = wide[DATA_BUS_WIDTH];
   assign Z      = (result == '0);
   assign N      = result[DATA_BUS_WIDTH-1];

endmodule

// File: rtl/alu_exec_sequencer.sv
// Execute-stage sequencer: latch operands, run the ALU, capture ALUOut and Z/C/N status.
module alu_exec_sequencer
   import alu_exec_sequencer_pkg::*;
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [ALU_OP_NUM_BITS-1:0] op_in,
   input  logic [DATA_BUS_WIDTH-1:0]  src_a,
   input  logic [DATA_BUS_WIDTH-1:0]  src_b,
   input  logic                       chain_a,
   input  logic                       flag_we,
   output logic                       busy,
   output logic                       done,
   output logic                       illegal_op,
   output logic [DATA_BUS_WIDTH-1:0]  alu_out,
   output logic                       flag_z,
   output logic                       flag_c,
   output logic                       flag_n
);

   state_e                       state_q, state_d;
   logic [ALU_OP_NUM_BITS-1:0]   op_q;
   logic [DATA_BUS_WIDTH-1:0]    a_q, a_d, b_q;
   logic                         flag_we_q;
   logic [DATA_BUS_WIDTH-1:0]    alu_out_q;
   logic                         z_q, c_q, n_q;
   logic [DATA_BUS_WIDTH-1:0]    alu_res;
   logic                         alu_z, alu_c, alu_n;
   logic                         accept;

   assign accept = (state_q == ST_IDLE) && start;
   assign a_d    = chain_a ? alu_out_q : src_a;

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_LATCH;
         ST_LATCH: state_d = ST_EXEC;
         ST_EXEC:  state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy       = (state_q != ST_IDLE);
      done       = (state_q == ST_DONE);
      illegal_op = (state_q == ST_DONE) && (op_q == ALU_OP_UNDEF);
   end

   alu_exec_sequencer_alu u_alu (
      .a      (a_q),
      .b      (b_q),
      .ALU_OP (op_q),
      .result (alu_res),
      .Z      (alu_z),
      .C      (alu_c),
      .N      (alu_n)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         flag_we_q <= 1'b0;
         alu_out_q <= '0;
         z_q       <= 1'b0;
         c_q       <= 1'b0;
         n_q       <= 1'b0;
      end else begin
         if (accept) begin
            op_q      <= op_in;
            a_q       <= a_d;
            b_q       <= src_b;
            flag_we_q <= flag_we;
         end
         if (state_q == ST_EXEC) begin
            alu_out_q <= alu_res;
            if (flag_we_q) begin
               z_q <= alu_z;
               n_q <= alu_n;
               if (op_sets_carry(op_q)) c_q <= alu_c;
            end
         end
      end
   end

   assign alu_out = alu_out_q;
   assign flag_z  = z_q;
   assign flag_c  = c_q;
   assign flag_n  = n_q;

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Scoreboard bench: driver pushes model predictions, monitor pops and compares on each done pulse.
module tb_alu_exec_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op_in;
   logic [23:0] src_a, src_b;
   logic        chain_a, flag_we;
   logic        busy, done, illegal_op;
   logic [23:0] alu_out;
   logic        flag_z, flag_c, flag_n;

   alu_exec_sequencer dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .op_in      (op_in),
      .src_a      (src_a),
      .src_b      (src_b),
      .chain_a    (chain_a),
      .flag_we    (flag_we),
      .busy       (busy),
      .done       (done),
      .illegal_op (illegal_op),
      .alu_out    (alu_out),
      .flag_z     (flag_z),
      .flag_c     (flag_c),
      .flag_n     (flag_n)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] out;
      logic        z, c, n, ill;
      int unsigned cyc;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc = 0;
   int unsigned total = 0;
   int unsigned bad = 0;
   int unsigned done_cnt = 0;
   int unsigned issued = 0;

   // Architectural state of the reference model
   logic [23:0] m_out;
   logic        m_z, m_c, m_n;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_out = '0; m_z = 1'b0; m_c = 1'b0; m_n = 1'b0;
   endtask

   task automatic expect_op(input logic [2:0] op, input logic [23:0] a, input logic [23:0] b,
                            input logic ch, input logic we);
      int unsigned x, y, w;
      exp_t e;
      x = ch ? int'(m_out) : int'(a);
      y = int'(b);
      case (op)
         3'd0:    w = x + y;
         3'd1:    w = (x - y) & 32'h1FF_FFFF;
         3'd2:    w = x & y;
         3'd3:    w = x | y;
         3'd4:    w = x ^ y;
         3'd5:    w = (~x) & 32'hFF_FFFF;
         3'd6:    w = x + 1;
         default: w = 0;
      endcase
      m_out = w[23:0];
      if (we) begin
         m_z = (w[23:0] == 24'd0);
         m_n = w[23];
         if (op == 3'd0 || op == 3'd1 || op == 3'd6) m_c = w[24];
      end
      e.out = m_out; e.z = m_z; e.c = m_c; e.n = m_n;
      e.ill = (op == 3'd7);
      e.cyc = cyc + 3;
      sb.push_back(e);
      issued++;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy !== 1'b0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (busy !== 1'b0) chk("idle_timeout", {31'd0, busy}, 32'd0);
   endtask

   task automatic issue(input logic [2:0] op, input logic [23:0] a, input logic [23:0] b,
                        input logic ch, input logic we);
      wait_idle();
      expect_op(op, a, b, ch, we);
      op_in = op; src_a = a; src_b = b; chain_a = ch; flag_we = we;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (illegal_op === 1'b1 && done !== 1'b1) chk("illegal_without_done", 32'd1, 32'd0);
      if (done === 1'b1) begin
         done_cnt++;
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("alu_out", {8'd0, alu_out}, {8'd0, e.out});
            chk("flag_z", {31'd0, flag_z}, {31'd0, e.z});
            chk("flag_c", {31'd0, flag_c}, {31'd0, e.c});
            chk("flag_n", {31'd0, flag_n}, {31'd0, e.n});
            chk("illegal_op", {31'd0, illegal_op}, {31'd0, e.ill});
            chk("done_latency", cyc, e.cyc);
         end
      end
   end

   initial begin
      logic [4:0]  bp;
      int unsigned d0;

      reset = 1'b1; start = 1'b0; op_in = '0; src_a = '0; src_b = '0;
      chain_a = 1'b0; flag_we = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_alu_out", {8'd0, alu_out}, 32'd0);
      chk("rst_flags", {29'd0, flag_z, flag_c, flag_n}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Directed vectors
      issue(3'd0, 24'hFFFFFF, 24'h000001, 1'b0, 1'b1);
      wait_idle();
      chk("add_wrap_out", {8'd0, alu_out}, 32'd0);
      chk("add_wrap_zcn", {29'd0, flag_z, flag_c, flag_n}, 32'b110);
      issue(3'd1, 24'd5, 24'd7, 1'b0, 1'b1);
      issue(3'd1, 24'd7, 24'd5, 1'b0, 1'b1);
      issue(3'd0, 24'd1, 24'd1, 1'b0, 1'b1);
      issue(3'd5, 24'h0ABCDE, 24'd0, 1'b1, 1'b1);
      wait_idle();
      chk("not_chain_out", {8'd0, alu_out}, 32'h00FFFFFD);
      chk("not_chain_zcn", {29'd0, flag_z, flag_c, flag_n}, 32'b001);

      // Start held through LATCH/EXEC/DONE must be ignored
      wait_idle();
      d0 = done_cnt;
      bp[4] = busy;
      expect_op(3'd3, 24'h00F00F, 24'h0F0F00, 1'b0, 1'b1);
      op_in = 3'd3; src_a = 24'h00F00F; src_b = 24'h0F0F00; chain_a = 1'b0; flag_we = 1'b1;
      start = 1'b1;
      for (int i = 3; i >= 0; i--) begin
         @(negedge clk);
         bp[i] = busy;
         op_in = 3'($urandom_range(0, 7)); src_a = 24'($urandom); src_b = 24'($urandom);
      end
      start = 1'b0;
      chk("busy_pattern", {27'd0, bp}, 32'b01110);
      repeat (4) @(negedge clk);
      chk("single_done", done_cnt - d0, 32'd1);

      // Undefined opcode: carry must survive, set it first
      issue(3'd1, 24'd0, 24'd1, 1'b0, 1'b1);
      issue(3'd7, 24'h123456, 24'h000042, 1'b0, 1'b1);
      wait_idle();
      chk("undef_out", {8'd0, alu_out}, 32'd0);
      chk("undef_zcn", {29'd0, flag_z, flag_c, flag_n}, 32'b110);

      // Reset while in EXEC discards the in-flight op
      issue(3'd0, 24'h800000, 24'h000001, 1'b0, 1'b1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_done", {31'd0, done}, 32'd0);
      chk("midrst_out", {8'd0, alu_out}, 32'd0);
      chk("midrst_flags", {29'd0, flag_z, flag_c, flag_n}, 32'd0);
      sb.delete();
      issued--;
      model_reset();
      reset = 1'b0;
      repeat (4) @(negedge clk);
      issue(3'd0, 24'hFFFFFF, 24'h000002, 1'b0, 1'b0);

      // Reset and start together: reset wins
      wait_idle();
      reset = 1'b1; start = 1'b1; op_in = 3'd0;
      @(negedge clk);
      reset = 1'b0; start = 1'b0;
      chk("rst_start_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk("rst_start_busy2", {31'd0, busy}, 32'd0);
      model_reset();

      // Randomized traffic
      for (int i = 0; i < 200; i++) begin
         issue(3'($urandom_range(0, 7)), 24'($urandom), 24'($urandom),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end

      wait_idle();
      repeat (4) @(negedge clk);
      chk("sb_drained", sb.size(), 32'd0);
      chk("done_count", done_cnt, issued);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
